f1_sweep_checker: RTL and testbench

//  Upstream stimulus and response checker for the F1 4-input function implementations.
//  On start, drives all 16 input vectors {a,b,c,d} (a = MSB) into an F1 implementation.

---
 rtl/f1_sweep_checker.sv | 87 ++++++++
 tb/tb_f1_sweep_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/f1_sweep_checker.sv
// Sweeps all 16 {a,b,c,d} vectors into an F1 implementation and checks f1 against TRUTH_TABLE.
// Optional build macro: F1_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module f1_sweep_checker #(
    parameter logic [15:0] TRUTH_TABLE = 16'hBD05,
    parameter int          SETTLE      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f1,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [3:0]  first_fail_idx,
    output logic [15:0] fail_map
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

    state_t        state, state_nxt;
    logic [3:0]    vec;
    logic [CW-1:0] cnt;
    logic          mismatch;

    assign mismatch     = (f1 != TRUTH_TABLE[vec]);
    assign {a, b, c, d} = vec;
    assign busy         = (state == DRIVE) || (state == SAMPLE);
    assign done         = (state == FIN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = DRIVE;
            DRIVE:  if (cnt == CNT_LAST) state_nxt = SAMPLE;
`ifdef F1_CHK_STOP_ON_FAIL_EN
            SAMPLE: state_nxt = (mismatch || vec == 4'd15) ? FIN : DRIVE;
`else
            SAMPLE: state_nxt = (vec == 4'd15) ? FIN : DRIVE;
`endif
            FIN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            vec            <= 4'd0;
            cnt            <= '0;
            pass           <= 1'b0;
            err_cnt        <= 5'd0;
            first_fail_idx <= 4'd0;
            fail_map       <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    vec            <= 4'd0;
                    cnt            <= '0;
                    pass           <= 1'b0;
                    err_cnt        <= 5'd0;
                    first_fail_idx <= 4'd0;
                    fail_map       <= 16'd0;
                end
                DRIVE: cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                SAMPLE: begin
                    if (mismatch) begin
                        fail_map[vec] <= 1'b1;
                        err_cnt       <= err_cnt + 5'd1;
                        if (err_cnt == 5'd0) first_fail_idx <= vec;
                    end
                    if (state_nxt == DRIVE) vec <= vec + 4'd1;
                    // pass resolves with the final sample included so it is valid alongside done
                    if (state_nxt == FIN) pass <= (err_cnt == 5'd0) && !mismatch;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_f1_sweep_checker.sv
// Directed bench for f1_sweep_checker: ideal, stuck-at-0 and inverted F1 models, reset and start abuse.
module tb_f1_sweep_checker;
    localparam logic [15:0] TT = 16'hBD05;

    logic        clk = 0, rst = 1, start = 0;
    logic        f1, a, b, c, d, busy, done, pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first_fail_idx;
    logic [15:0] fail_map;
    logic [3:0]  vec;
    int          mode = 0;
    int          n_pass = 0, n_tot = 0;
    int          cyc;
    logic        saw_done;

`ifdef F1_CHK_STOP_ON_FAIL_EN
    localparam int          FAIL_CYC = 4;
    localparam int          FAIL_ERR = 1;
    localparam logic [15:0] MAP0     = 16'h0001;
    localparam logic [15:0] MAPINV   = 16'h0001;
    localparam int          FAIL_VEC = 0;
`else
    localparam int          FAIL_CYC = 49;
    localparam int          FAIL_ERR = 8;
    localparam logic [15:0] MAP0     = 16'hBD05;
    localparam logic [15:0] MAPINV   = 16'hFFFF;
    localparam int          FAIL_VEC = 15;
`endif

    assign vec = {a, b, c, d};
    assign f1  = (mode == 0) ? TT[vec] : (mode == 1) ? 1'b0 : ~TT[vec];

    f1_sweep_checker #(.TRUTH_TABLE(16'hBD05), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .f1(f1),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail_idx(first_fail_idx), .fail_map(fail_map)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Start at cycle 0, optionally pulse start again at cycle poke, return the cycle done was seen.
    task automatic run_sweep(input int poke, output int cyc_done);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        cyc_done = 0;
        while (cyc_done < 200) begin
            @(negedge clk);
            cyc_done++;
            if (done) break;
            start = (cyc_done == poke);
        end
        start = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_map", fail_map, 0);
        chk("rst_vec", vec, 0);
        rst = 0;
        @(negedge clk);

        // 1: ideal model
        mode = 0;
        run_sweep(0, cyc);
        chk("ideal_cyc", cyc, 49);
        chk("ideal_pass", pass, 1);
        chk("ideal_err", err_cnt, 0);
        chk("ideal_map", fail_map, 0);
        chk("ideal_busy", busy, 0);
        chk("ideal_vec", vec, 15);
        @(negedge clk);
        chk("ideal_done_1cyc", done, 0);

        // 2: f1 stuck at 0
        mode = 1;
        run_sweep(0, cyc);
        chk("zero_cyc", cyc, FAIL_CYC);
        chk("zero_err", err_cnt, FAIL_ERR);
        chk("zero_map", fail_map, MAP0);
        chk("zero_ffi", first_fail_idx, 0);
        chk("zero_pass", pass, 0);
        chk("zero_vec", vec, FAIL_VEC);
        repeat (3) @(negedge clk);
        chk("zero_hold_err", err_cnt, FAIL_ERR);

        // 3: inverted golden, count must reach 16 without wrapping
        mode = 2;
        run_sweep(0, cyc);
        chk("inv_cyc", cyc, FAIL_CYC);
        chk("inv_err", err_cnt, FAIL_ERR == 8 ? 16 : 1);
        chk("inv_map", fail_map, MAPINV);
        chk("inv_ffi", first_fail_idx, 0);
        chk("inv_pass", pass, 0);
        @(negedge clk);

        // 4: reset mid-sweep
        mode = 1;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (19) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_map", fail_map, 0);
        chk("mid_rst_ffi", first_fail_idx, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_vec", vec, 0);
        saw_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("mid_rst_no_done", saw_done, 0);
        mode = 0;
        run_sweep(0, cyc);
        chk("post_rst_cyc", cyc, 49);
        chk("post_rst_pass", pass, 1);
        @(negedge clk);

        // 5: start pulsed while busy is ignored; new start clears stale results
        mode = 1;
        run_sweep(0, cyc);
        @(negedge clk);
        mode = 0;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        chk("restart_err_clr", err_cnt, 0);
        chk("restart_map_clr", fail_map, 0);
        chk("restart_busy", busy, 1);
        cyc = 1;
        while (cyc < 200 && !done) begin
            start = (cyc == 10 || cyc == 30);
            @(negedge clk);
            cyc++;
        end
        start = 0;
        chk("poke_cyc", cyc, 49);
        chk("poke_pass", pass, 1);
        @(negedge clk);
        chk("poke_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
